mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the 4-to-1 mux datapath (inputs A_in/B_in/C_in/D_in, selects S1/S0).
- Shares the single mux output among four requesters.
- Registers a one-hot grant and drives S1/S0 so the granted source appears on Mux_out.
- Bounds each grant to MAX_HOLD cycles whenever another requester is waiting.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for a holder while any other requester is waiting. Legal range >= 1.
- CNT_W, 4: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD-1.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Req_in  in  4  request vector; bit0=A, bit1=B, bit2=C, bit3=D.
- Grant_out  out  4  registered grant, one-hot or all-zero.
- S0  out  1  mux select LSB, registered.
- S1  out  1  mux select MSB, registered.
- Valid_out  out  1  high while a grant is active; Mux_out is meaningful only then.
- Lock_in  in  1  present only when MUX_ARB_LOCK_EN is defined (see Optional Feature).

Interface decisions:
- One clock; reset is synchronous and active-high (CLK, RST).

Behaviour:
- Reset values (RST=1 at a rising edge):
  - state=IDLE, Grant_out=4'b0000, Valid_out=0, {S1,S0}=2'b00.
  - Hold counter=0; last-grant pointer=3, so index 0 has first priority.
- RST mid-grant: reset values apply at that same edge, regardless of Req_in.
- Select encoding: {S1,S0}=granted index (A=00, B=01, C=10, D=11).
  - S1/S0 change only when a new grant is issued.
  - While Valid_out=0, S1/S0 hold the last granted index.
- Round-robin pick: search the indices (ptr+1, ptr+2, ptr+3, ptr) mod 4; the first with Req_in set wins. Wrap-around 3->0 is required.
- IDLE state:
  - Req_in=0: stay in IDLE, outputs unchanged.
  - Any Req_in bit set: go to GRANT.
  - Next edge: Grant_out=one-hot(pick), {S1,S0}=pick, Valid_out=1, ptr=pick, counter=0.
  - Latency from Req_in sampled high to Grant_out high is 1 cycle.
- GRANT state, holder h, evaluated each edge:
  - Req_in[h]=1 and no other request: keep grant; counter increments, saturating at MAX_HOLD-1.
  - Req_in[h]=1, another request, counter<MAX_HOLD-1: keep grant; counter increments.
  - Req_in[h]=1, another request, counter==MAX_HOLD-1 (preempt): regrant to pick from ptr=h at the next edge; counter=0. No idle gap.
  - Req_in[h]=0 and others request: regrant to pick from h at the next edge; counter=0. No gap.
  - Req_in[h]=0 and no requests: go to IDLE; Grant_out=0, Valid_out=0, S1/S0 held, ptr=h.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Invariants:
  - Grant_out is never multi-hot.
  - Valid_out == |Grant_out.
  - {S1,S0} matches the Grant_out index whenever Valid_out=1.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds Lock_in.
  - While in GRANT with Req_in[h]=1 and Lock_in=1, preemption is suppressed; the counter still saturates at MAX_HOLD-1.
  - When Lock_in falls with counter saturated and others waiting, preemption occurs at the next edge.
  - Lock_in is ignored in IDLE and when Req_in[h]=0.
- Undefined: no Lock_in port; preemption always applies as described in Behaviour.

Test Plan:
- Reset: RST=1 for 2 cycles with Req_in=4'b1111 -> Grant_out=0000, Valid_out=0, {S1,S0}=00. Release RST -> next edge Grant_out=0001, {S1,S0}=00.
- Single requester: Req_in=0100 held 20 cycles -> Grant_out=0100, {S1,S0}=10 for all 20 cycles. Drop Req -> next edge Valid_out=0, {S1,S0} stays 10.
- Rotation and wrap, MAX_HOLD=8: Req_in=1111 constant -> grants 0001,0010,0100,1000,0001, each exactly 8 cycles; S1/S0 follow 00,01,10,11,00.
- Early release: holder B (0010) drops Req at cycle 3 while Req_in=1001 -> next edge Grant_out=1000, {S1,S0}=11, no Valid_out gap. With the mux datapath attached, Mux_out equals D_in.
- Mid-grant reset: RST=1 during a D grant at counter=5 -> next edge all outputs at reset values. With Req_in=1111 after release -> first grant is A (0001).
- MUX_ARB_LOCK_EN, Req_in=0011, A holding, Lock_in=1 for 15 cycles -> A held 15 cycles. Lock_in=0 -> next edge Grant_out=0010.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4-to-1 mux, with bounded hold time.
// Optional MUX_ARB_LOCK_EN adds Lock_in, which suppresses preemption of the current holder.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Req_in,
`ifdef MUX_ARB_LOCK_EN
  input  logic       Lock_in,
`endif
  output logic [3:0] Grant_out,
  output logic       S0,
  output logic       S1,
  output logic       Valid_out
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       pick;
  logic             holder_req;
  logic             others_req;
  logic             lock;
  logic [CNT_W-1:0] cnt_next_sat;

  // First requester after ptr in circular order; ptr itself is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

`ifdef MUX_ARB_LOCK_EN
  assign lock = Lock_in;
`else
  assign lock = 1'b0;
`endif

  // In GRANT, ptr always equals the current holder index.
  always_comb begin
    pick         = rr_pick(Req_in, ptr);
    holder_req   = Req_in[ptr];
    others_req   = |(Req_in & ~(4'b0001 << ptr));
    cnt_next_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  // NOTE: all state here is registered with non-blocking assignments so every
  // branch sees the pre-edge values of ptr/cnt regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      Grant_out <= 4'b0000;
      Valid_out <= 1'b0;
      sel       <= 2'b00;
      cnt       <= '0;
      ptr       <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (|Req_in) begin
            state     <= GRANT;
            Grant_out <= 4'b0001 << pick;
            Valid_out <= 1'b1;
            sel       <= pick;
            ptr       <= pick;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (holder_req && (!others_req || cnt != CNT_MAX || lock)) begin
            cnt <= cnt_next_sat;
          end else if (|Req_in) begin
            // Preemption or release with waiters: hand over without an idle cycle.
            Grant_out <= 4'b0001 << pick;
            sel       <= pick;
            ptr       <= pick;
            cnt       <= '0;
          end else begin
            state     <= IDLE;
            Grant_out <= 4'b0000;
            Valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {S1, S0} = sel;

  a_onehot : assert property (@(posedge CLK) disable iff (RST) $onehot0(Grant_out));
  a_valid  : assert property (@(posedge CLK) disable iff (RST) Valid_out == |Grant_out);
  a_sel    : assert property (@(posedge CLK) disable iff (RST)
                              Valid_out |-> Grant_out[sel]);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed stimulus pushes hand-computed
// {Grant_out, Valid_out, S1, S0} per cycle; a monitor pops and compares after each edge.
module tb_mux4_rr_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] Req_in;
  logic       Lock_in;
  logic [3:0] Grant_out;
  logic       S0, S1, Valid_out;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_in    (Req_in),
`ifdef MUX_ARB_LOCK_EN
    .Lock_in   (Lock_in),
`endif
    .Grant_out (Grant_out),
    .S0        (S0),
    .S1        (S1),
    .Valid_out (Valid_out)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic ev, input logic [1:0] es);
    item_t it;
    @(negedge CLK);
    RST    = r;
    Req_in = rq;
    it.name = name;
    it.exp  = {eg, ev, es};
    q.push_back(it);
    @(posedge CLK);
  endtask

  initial begin : monitor
    item_t      it;
    logic [6:0] act;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        it  = q.pop_front();
        act = {Grant_out, Valid_out, S1, S0};
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got grant=%b valid=%b sel=%b, want grant=%b valid=%b sel=%b",
                   it.name, act[6:3], act[2], act[1:0], it.exp[6:3], it.exp[2], it.exp[1:0]);
        end
      end
    end
  end

  initial begin : stim
    RST     = 1'b1;
    Req_in  = 4'b0000;
    Lock_in = 1'b0;

    // Reset with all requests pending, then release: A wins first.
    repeat (2) step("reset", 1'b1, 4'b1111, 4'b0000, 1'b0, 2'b00);
    step("release", 1'b0, 4'b1111, 4'b0001, 1'b1, 2'b00);

    // Full contention: each grant lasts exactly 8 cycles, wrapping D -> A.
    repeat (7) step("rot_a0", 1'b0, 4'b1111, 4'b0001, 1'b1, 2'b00);
    repeat (8) step("rot_b",  1'b0, 4'b1111, 4'b0010, 1'b1, 2'b01);
    repeat (8) step("rot_c",  1'b0, 4'b1111, 4'b0100, 1'b1, 2'b10);
    repeat (8) step("rot_d",  1'b0, 4'b1111, 4'b1000, 1'b1, 2'b11);
    repeat (8) step("rot_a1", 1'b0, 4'b1111, 4'b0001, 1'b1, 2'b00);

    // All requests drop: idle, select holds A.
    step("idle0", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);

    // Single requester C for 20 cycles, then release; select holds C.
    repeat (20) step("single_c", 1'b0, 4'b0100, 4'b0100, 1'b1, 2'b10);
    step("idle_c", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b10);

    // B granted from idle, releases after 3 cycles while A and D wait: D next, no gap.
    repeat (3) step("hold_b", 1'b0, 4'b0010, 4'b0010, 1'b1, 2'b01);
    step("early_rel", 1'b0, 4'b1001, 4'b1000, 1'b1, 2'b11);

    // D holds to counter=5, then reset mid-grant; A first afterwards.
    repeat (5) step("hold_d", 1'b0, 4'b1000, 4'b1000, 1'b1, 2'b11);
    step("mid_reset", 1'b1, 4'b1111, 4'b0000, 1'b0, 2'b00);
    step("post_reset", 1'b0, 4'b1111, 4'b0001, 1'b1, 2'b00);

    // A alone long enough to saturate; a newcomer C preempts at the very next edge.
    repeat (10) step("sat_a", 1'b0, 4'b0001, 4'b0001, 1'b1, 2'b00);
    step("sat_preempt", 1'b0, 4'b0101, 4'b0100, 1'b1, 2'b10);
    step("idle2", 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b10);

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps A for 15 cycles despite B waiting; unlocking hands over to B.
    step("lock_a0", 1'b0, 4'b0001, 4'b0001, 1'b1, 2'b00);
    Lock_in = 1'b1;
    repeat (14) step("lock_a", 1'b0, 4'b0011, 4'b0001, 1'b1, 2'b00);
    Lock_in = 1'b0;
    step("unlock", 1'b0, 4'b0011, 4'b0010, 1'b1, 2'b01);
`endif

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected items left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
